// File: rtl/fs_serial_loader.sv
// fs_serial_loader: on-demand variable-length serial load (sclk/sdata/le) behind a valid/ready handshake
module fs_serial_loader #(
  parameter int DATA_W    = 32,
  parameter int CLK_DIV   = 2,
  parameter int LE_W      = 3,
  parameter int LSB_FIRST = 1,
  parameter int LEN_W     = $clog2(DATA_W + 1)
) (
  input  logic              clkIN,
  input  logic              resetIN,
  input  logic [DATA_W-1:0] dataIN,
  input  logic [LEN_W-1:0]  lenIN,
  input  logic              validIN,
  output logic              readyOUT,
  output logic              busyOUT,
  output logic              sclkOUT,
  output logic              sdataOUT,
  output logic              leOUT,
  output logic              doneOUT
);
  localparam int DW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
  localparam int LW = LE_W > 1 ? $clog2(LE_W) : 1;
  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  state_t r_state, w_state;
  logic [DATA_W-1:0] r_shift, w_shift, w_align, w_nshift;
  logic [LEN_W-1:0] r_len, w_len_n, r_bit, w_bit, w_len;
  logic [DW-1:0] r_div, w_div;
  logic [LW-1:0] r_le_cnt, w_le_cnt;
  logic r_sclk, w_sclk, r_sdata, w_sdata, r_le, w_le, r_done, w_done, r_ready;
  logic w_first, w_nbit, w_div_end;
  assign w_len     = (lenIN == '0 || lenIN > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : lenIN;
  // MSB-first words are pre-aligned so bit len-1 sits at the top of the shifter
  assign w_align   = (LSB_FIRST != 0) ? dataIN : dataIN << (LEN_W'(DATA_W) - w_len);
  assign w_nshift  = (LSB_FIRST != 0) ? r_shift >> 1 : r_shift << 1;
  assign w_first   = (LSB_FIRST != 0) ? w_align[0] : w_align[DATA_W-1];
  assign w_nbit    = (LSB_FIRST != 0) ? w_nshift[0] : w_nshift[DATA_W-1];
  assign w_div_end = r_div == DW'(CLK_DIV - 1);
  always_comb begin
    w_state  = r_state;
    w_shift  = r_shift;
    w_len_n  = r_len;
    w_bit    = r_bit;
    w_div    = r_div;
    w_le_cnt = r_le_cnt;
    w_sclk   = r_sclk;
    w_sdata  = r_sdata;
    w_le     = r_le;
    w_done   = 1'b0;
    case (r_state)
      IDLE: if (validIN) begin
        w_state = SHIFT;
        w_shift = w_align;
        w_len_n = w_len;
        w_bit   = '0;
        w_div   = '0;
        w_sclk  = 1'b0;
        w_sdata = w_first;
      end
      SHIFT: begin
        w_div = w_div_end ? '0 : r_div + 1'b1;
        if (w_div_end && !r_sclk) w_sclk = 1'b1;
        else if (w_div_end && r_bit == r_len - 1'b1) begin
          w_state  = LATCH;
          w_sclk   = 1'b0;
          w_sdata  = 1'b0;
          w_le     = 1'b1;
          w_le_cnt = '0;
        end else if (w_div_end) begin
          w_sclk  = 1'b0;
          w_bit   = r_bit + 1'b1;
          w_shift = w_nshift;
          w_sdata = w_nbit;
        end
      end
      LATCH: if (r_le_cnt == LW'(LE_W - 1)) begin
        w_state = IDLE;
        w_le    = 1'b0;
        w_done  = 1'b1;
      end else w_le_cnt = r_le_cnt + 1'b1;
      default: w_state = IDLE;
    endcase
  end
  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      r_state  <= IDLE;
      r_shift  <= '0;
      r_len    <= '0;
      r_bit    <= '0;
      r_div    <= '0;
      r_le_cnt <= '0;
      r_sclk   <= 1'b0;
      r_sdata  <= 1'b0;
      r_le     <= 1'b0;
      r_done   <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      r_state  <= w_state;
      r_shift  <= w_shift;
      r_len    <= w_len_n;
      r_bit    <= w_bit;
      r_div    <= w_div;
      r_le_cnt <= w_le_cnt;
      r_sclk   <= w_sclk;
      r_sdata  <= w_sdata;
      r_le     <= w_le;
      r_done   <= w_done;
      r_ready  <= w_state == IDLE;
    end
  end
  assign readyOUT = r_ready;
  assign busyOUT  = ~r_ready;
  assign sclkOUT  = r_sclk;
  assign sdataOUT = r_sdata;
  assign leOUT    = r_le;
  assign doneOUT  = r_done;
endmodule

// File: tb/tb_fs_serial_loader.sv
// tb_fs_serial_loader: scoreboard bench for two loader instances (LSB-first div 2, MSB-first div 1)
module tb_fs_serial_loader;
  localparam int LE_W = 3;
  typedef struct {logic [31:0] bits; int n;} exp_t;
  logic clk = 1'b0;
  logic [1:0] rst = 2'b11, valid = 2'b00;
  logic [1:0] ready, busy, sclk, sdata, le, done;
  logic [31:0] data [2];
  logic [5:0] len [2];
  int cyc = 0, total = 0, bad = 0;
  exp_t q0[$], q1[$];
  bit fin = 0, mon_done = 0;
  bit act [2];
  int start [2], nr [2], le_n [2], le_first [2];
  logic [31:0] got [2];
  logic psclk [2], psdata [2];
  bit rstp [2];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  fs_serial_loader u0 (.clkIN(clk), .resetIN(rst[0]), .dataIN(data[0]), .lenIN(len[0]), .validIN(valid[0]),
    .readyOUT(ready[0]), .busyOUT(busy[0]), .sclkOUT(sclk[0]), .sdataOUT(sdata[0]), .leOUT(le[0]), .doneOUT(done[0]));
  fs_serial_loader #(.CLK_DIV(1), .LSB_FIRST(0)) u1 (.clkIN(clk), .resetIN(rst[1]), .dataIN(data[1]), .lenIN(len[1]),
    .validIN(valid[1]), .readyOUT(ready[1]), .busyOUT(busy[1]), .sclkOUT(sclk[1]), .sdataOUT(sdata[1]), .leOUT(le[1]),
    .doneOUT(done[1]));
  function automatic int cdv(int k); return k == 0 ? 2 : 1; endfunction
  function automatic exp_t model(int k, logic [31:0] d, logic [5:0] l);
    exp_t m;
    m.n = (l == 0 || l > 32) ? 32 : int'(l);
    m.bits = '0;
    for (int i = 0; i < m.n; i++) m.bits[i] = (k == 0) ? d[i] : d[m.n-1-i];
    return m;
  endfunction
  task automatic chk(input bit ok, input string nm, input int k, input longint a, input longint e);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s[u%0d] got=%0h exp=%0h @cyc %0d", nm, k, a, e, cyc);
    end
  endtask
  function automatic int qsize(int k); return k == 0 ? q0.size() : q1.size(); endfunction
  function automatic exp_t qpop(int k); return k == 0 ? q0.pop_front() : q1.pop_front(); endfunction
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      if (rstp[k]) chk({ready[k], busy[k], sclk[k], sdata[k], le[k], done[k]} == 6'b100000, "reset_out", k,
        {ready[k], busy[k], sclk[k], sdata[k], le[k], done[k]}, 6'b100000);
      rstp[k] = rst[k];
      if (rst[k]) begin
        if (act[k]) e = qpop(k);
        act[k] = 0;
      end else begin
        chk(busy[k] == ~ready[k], "busy_vs_ready", k, busy[k], ~ready[k]);
        if (ready[k]) chk({sclk[k], sdata[k], le[k]} == 3'b000, "idle_static", k, {sclk[k], sdata[k], le[k]}, 0);
        chk(!(le[k] && sclk[k]), "le_with_sclk", k, le[k] & sclk[k], 0);
        if (sclk[k] && psclk[k]) chk(sdata[k] == psdata[k], "sdata_stable", k, sdata[k], psdata[k]);
        if (sclk[k] && !psclk[k]) begin
          chk(act[k], "stray_rise", k, 1, 0);
          if (act[k]) begin
            chk(cyc == start[k] + cdv(k) + 2 * cdv(k) * nr[k], "rise_time", k, cyc - start[k],
              cdv(k) + 2 * cdv(k) * nr[k]);
            if (nr[k] < 32) got[k][nr[k]] = sdata[k];
            nr[k]++;
          end
        end
        if (le[k]) begin
          chk(act[k], "stray_le", k, 1, 0);
          if (le_n[k] == 0) le_first[k] = cyc;
          le_n[k]++;
        end
        if (act[k] && !done[k]) chk(!ready[k], "ready_while_busy", k, ready[k], 0);
        if (done[k]) begin
          chk(act[k] && qsize(k) > 0, "unexpected_done", k, qsize(k), 1);
          if (act[k] && qsize(k) > 0) begin
            e = qpop(k);
            chk(nr[k] == e.n, "rise_count", k, nr[k], e.n);
            chk(got[k] == e.bits, "bits", k, got[k], e.bits);
            chk(cyc - start[k] == 2 * cdv(k) * e.n + LE_W, "latency", k, cyc - start[k], 2 * cdv(k) * e.n + LE_W);
            chk(le_first[k] - start[k] == 2 * cdv(k) * e.n, "le_start", k, le_first[k] - start[k], 2 * cdv(k) * e.n);
            chk(le_n[k] == LE_W, "le_width", k, le_n[k], LE_W);
          end
          act[k] = 0;
        end
        if (act[k] && cyc - start[k] > 2 * cdv(k) * 32 + LE_W + 10) begin
          chk(0 != 0 && act[k], "timeout", k, cyc - start[k], 2 * cdv(k) * 32 + LE_W);
          if (qsize(k) > 0) e = qpop(k);
          act[k] = 0;
        end
        if (valid[k] && ready[k]) begin
          act[k] = 1;
          start[k] = cyc + 1;
          nr[k] = 0;
          le_n[k] = 0;
          got[k] = '0;
        end
      end
      psclk[k] = sclk[k];
      psdata[k] = sdata[k];
    end
    if (fin && !mon_done) begin
      chk(q0.size() == 0 && q1.size() == 0 && !act[0] && !act[1], "drain", 0, q0.size() + q1.size(), 0);
      mon_done = 1;
    end
  end
  task automatic step(); @(posedge clk); #1; endtask
  task automatic send(input int k, input logic [31:0] d, input logic [5:0] l, input bit hold);
    for (int i = 0; i < 2000 && !ready[k]; i++) step();
    if (k == 0) q0.push_back(model(k, d, l)); else q1.push_back(model(k, d, l));
    valid[k] = 1'b1;
    data[k] = d;
    len[k] = l;
    step();
    if (!hold) valid[k] = 1'b0;
  endtask
  task automatic wait_idle(input int k);
    for (int i = 0; i < 2000 && !ready[k]; i++) step();
    step();
  endtask
  initial begin
    int r;
    logic p;
    data[0] = '0; data[1] = '0; len[0] = '0; len[1] = '0;
    for (int k = 0; k < 2; k++) begin act[k] = 0; psclk[k] = 0; psdata[k] = 0; rstp[k] = 0; end
    repeat (3) step();
    rst = 2'b00;
    step();
    send(0, 32'h0000_0010, 6'd0, 0); wait_idle(0);
    send(0, $urandom, 6'd40, 0); wait_idle(0);
    send(0, 32'h1, 6'd1, 0); wait_idle(0);
    send(0, 32'h1, 6'd4, 1); send(0, 32'h2, 6'd4, 0); wait_idle(0);
    send(0, $urandom, 6'd32, 0);
    r = 0; p = 1'b0;
    for (int i = 0; i < 2000 && r < 10; i++) begin
      step();
      if (sclk[0] && !p) r++;
      p = sclk[0];
    end
    rst[0] = 1'b1; step(); rst[0] = 1'b0;
    repeat (5) step();
    send(0, $urandom, 6'($urandom_range(1, 32)), 0); wait_idle(0);
    send(0, $urandom, 6'd4, 0);
    for (int j = 1; j <= 18; j++) begin
      valid[0] = (j == 3 || j == 10 || j == 17);
      data[0] = $urandom;
      step();
    end
    valid[0] = 1'b0;
    wait_idle(0);
    repeat (6) begin send(0, $urandom, 6'($urandom_range(0, 40)), 0); wait_idle(0); end
    send(1, 32'hFFFF_FFA5, 6'd8, 0); wait_idle(1);
    send(1, $urandom, 6'd0, 1); send(1, $urandom, 6'd5, 0); wait_idle(1);
    repeat (6) begin send(1, $urandom, 6'($urandom_range(0, 40)), 0); wait_idle(1); end
    repeat (5) step();
    fin = 1;
    for (int i = 0; i < 10 && !mon_done; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
